obi_sram_sub: RTL and testbench

OBI subordinate that terminates the flattened `s_obi_*` bus with a single-port word-addressed memory and a small response queue. It sits directly downstream of the OBI manager and consumes its request/response traffic. It gives the cocotb manager BFM a real target with:
- byte-enabled writes,
- read-back,
- `aid`→`rid` echo,
- `rready` backpressure,
- optional address-range errors.

---
 rtl/obi_sram_sub.sv | 104 ++++++++++
 tb/tb_obi_sram_sub.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/obi_sram_sub.sv
// OBI subordinate: single-port word memory plus an in-order response FIFO.
// Optional macro OBI_SRAM_SUB_ERR_EN turns addresses >= MEM_WORDS*4 into error responses.
module obi_sram_sub #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int MEM_WORDS  = 1024,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_obi_req,
    output logic                    s_obi_gnt,
    input  logic [ADDR_WIDTH-1:0]   s_obi_addr,
    input  logic                    s_obi_we,
    input  logic [DATA_WIDTH/8-1:0] s_obi_be,
    input  logic [DATA_WIDTH-1:0]   s_obi_wdata,
    input  logic [ID_WIDTH-1:0]     s_obi_aid,
    output logic                    s_obi_rvalid,
    input  logic                    s_obi_rready,
    output logic [DATA_WIDTH-1:0]   s_obi_rdata,
    output logic                    s_obi_err,
    output logic [ID_WIDTH-1:0]     s_obi_rid
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic [ID_WIDTH-1:0]   rid;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    rsp_t                  rsp_q [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  oor, push, pop;
    rsp_t                  push_rsp, head;

    assign idx = s_obi_addr[IDX_W+1:2];

`ifdef OBI_SRAM_SUB_ERR_EN
    assign oor = (s_obi_addr >> (IDX_W + 2)) != '0;
`else
    assign oor = 1'b0;
`endif

    logic unused_addr;
    assign unused_addr = ^s_obi_addr;

    assign s_obi_gnt = !rst && (cnt < CNT_W'(RSP_DEPTH));
    assign push      = s_obi_req && s_obi_gnt;
    assign pop       = s_obi_rvalid && s_obi_rready;

    // Read data is captured at acceptance, so a write one cycle earlier is already visible.
    always_comb begin
        push_rsp       = '0;
        push_rsp.rdata = (s_obi_we || oor) ? '0 : mem[idx];
        push_rsp.err   = oor;
        push_rsp.rid   = s_obi_aid;
    end

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push && s_obi_we && !oor) begin
            for (int i = 0; i < BE_W; i++)
                if (s_obi_be[i]) mem[idx][i*8 +: 8] <= s_obi_wdata[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (push) rsp_q[wr_ptr] <= push_rsp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Head outputs are forced to zero whenever nothing valid is presented.
    assign head         = rsp_q[rd_ptr];
    assign s_obi_rvalid = !rst && (cnt != '0);
    assign s_obi_rdata  = s_obi_rvalid ? head.rdata : '0;
    assign s_obi_err    = s_obi_rvalid ? head.err   : 1'b0;
    assign s_obi_rid    = s_obi_rvalid ? head.rid   : '0;
endmodule

// File: tb/tb_obi_sram_sub.sv
// Directed bench for obi_sram_sub with a response scoreboard and reference memory.
module tb_obi_sram_sub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_obi_req = 1'b0;
    logic        s_obi_gnt;
    logic [31:0] s_obi_addr = '0;
    logic        s_obi_we = 1'b0;
    logic [3:0]  s_obi_be = '0;
    logic [31:0] s_obi_wdata = '0;
    logic [0:0]  s_obi_aid = '0;
    logic        s_obi_rvalid;
    logic        s_obi_rready = 1'b0;
    logic [31:0] s_obi_rdata;
    logic        s_obi_err;
    logic [0:0]  s_obi_rid;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [0:0]  rid;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [1024];

    always #5 clk = ~clk;

    obi_sram_sub #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(1), .MEM_WORDS(1024), .RSP_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .s_obi_req(s_obi_req), .s_obi_gnt(s_obi_gnt), .s_obi_addr(s_obi_addr),
        .s_obi_we(s_obi_we), .s_obi_be(s_obi_be), .s_obi_wdata(s_obi_wdata),
        .s_obi_aid(s_obi_aid), .s_obi_rvalid(s_obi_rvalid), .s_obi_rready(s_obi_rready),
        .s_obi_rdata(s_obi_rdata), .s_obi_err(s_obi_err), .s_obi_rid(s_obi_rid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop and compare on each response handshake, predict on each grant.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] w;
        logic        oor;
        if (!rst && s_obi_rvalid && s_obi_rready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_rdata", s_obi_rdata, e.rdata);
                check("sb_err", {31'd0, s_obi_err}, {31'd0, e.err});
                check("sb_rid", {31'd0, s_obi_rid}, {31'd0, e.rid});
            end
        end
        if (!rst && s_obi_req && s_obi_gnt) begin
`ifdef OBI_SRAM_SUB_ERR_EN
            oor = s_obi_addr >= 32'h1000;
`else
            oor = 1'b0;
`endif
            e.err = oor;
            e.rid = s_obi_aid;
            if (s_obi_we) begin
                e.rdata = '0;
                if (!oor) begin
                    w = model[s_obi_addr[11:2]];
                    for (int b = 0; b < 4; b++)
                        if (s_obi_be[b]) w[b*8 +: 8] = s_obi_wdata[b*8 +: 8];
                    model[s_obi_addr[11:2]] = w;
                end
            end else begin
                e.rdata = oor ? 32'd0 : model[s_obi_addr[11:2]];
            end
            sb.push_back(e);
        end
    end

    // Drive one request and hold it until granted; returns 1 time unit after the accepting edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [0:0] aid);
        bit granted = 0;
        s_obi_req = 1'b1; s_obi_we = we; s_obi_addr = addr;
        s_obi_be = be; s_obi_wdata = wdata; s_obi_aid = aid;
        for (int i = 0; i < 20 && !granted; i++) begin
            @(negedge clk);
            granted = s_obi_gnt;
            if (!granted) @(posedge clk);
        end
        if (!granted) check("grant_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_obi_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", sb.size(), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", {31'd0, s_obi_gnt}, 32'd0);
        check("rst_rvalid", {31'd0, s_obi_rvalid}, 32'd0);
        check("rst_rdata", s_obi_rdata, 32'd0);
        check("rst_err", {31'd0, s_obi_err}, 32'd0);
        check("rst_rid", {31'd0, s_obi_rid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        s_obi_rready = 1'b1;

        // Basic write then read, one-cycle latency
        issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1);
        check("wr_lat_rvalid", {31'd0, s_obi_rvalid}, 32'd1);
        check("wr_rdata_zero", s_obi_rdata, 32'd0);
        issue(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
        check("rd_lat_rvalid", {31'd0, s_obi_rvalid}, 32'd1);
        check("rd_deadbeef", s_obi_rdata, 32'hDEADBEEF);
        check("rd_err", {31'd0, s_obi_err}, 32'd0);

        // Byte-enable merge
        issue(1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0);
        issue(1'b1, 32'h20, 4'h5, 32'hAABBCCDD, 1'b0);
        issue(1'b0, 32'h22, 4'h0, 32'h0, 1'b1);
        check("be_merge", s_obi_rdata, 32'h11BB33DD);
        drain();

        // Backpressure with a full queue
        s_obi_rready = 1'b0;
        issue(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 1'b1);
        s_obi_req = 1'b1; s_obi_we = 1'b0; s_obi_addr = 32'h10; s_obi_aid = 1'b0;
        @(negedge clk);
        check("full_gnt0_a", {31'd0, s_obi_gnt}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_gnt0_b", {31'd0, s_obi_gnt}, 32'd0);
        check("full_head_rid", {31'd0, s_obi_rid}, 32'd0);
        @(posedge clk); #1;
        s_obi_rready = 1'b1;
        @(negedge clk);
        check("full_gnt0_c", {31'd0, s_obi_gnt}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("after_pop_gnt", {31'd0, s_obi_gnt}, 32'd1);
        check("second_rid", {31'd0, s_obi_rid}, 32'd1);
        @(posedge clk); #1;
        s_obi_req = 1'b0;
        drain();

        // Back-to-back write then read, one grant per cycle
        s_obi_req = 1'b1; s_obi_we = 1'b1; s_obi_addr = 32'h40;
        s_obi_be = 4'hF; s_obi_wdata = 32'h5A5A1234; s_obi_aid = 1'b1;
        @(negedge clk);
        check("b2b_gnt_wr", {31'd0, s_obi_gnt}, 32'd1);
        @(posedge clk); #1;
        s_obi_we = 1'b0; s_obi_aid = 1'b0;
        @(negedge clk);
        check("b2b_gnt_rd", {31'd0, s_obi_gnt}, 32'd1);
        @(posedge clk); #1;
        s_obi_req = 1'b0;
        check("b2b_raw", s_obi_rdata, 32'h5A5A1234);
        drain();

        // Reset with two responses queued, plus a write attempted during reset
        s_obi_rready = 1'b0;
        issue(1'b0, 32'h10, 4'h0, 32'h0, 1'b1);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
        rst = 1'b1; s_obi_rready = 1'b1;
        s_obi_req = 1'b1; s_obi_we = 1'b1; s_obi_addr = 32'h40;
        s_obi_be = 4'hF; s_obi_wdata = 32'hBADBAD00;
        sb.delete();
        @(negedge clk);
        check("inrst_gnt", {31'd0, s_obi_gnt}, 32'd0);
        check("inrst_rvalid", {31'd0, s_obi_rvalid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; s_obi_req = 1'b0;
        @(negedge clk);
        check("postrst_gnt", {31'd0, s_obi_gnt}, 32'd1);
        check("postrst_rvalid", {31'd0, s_obi_rvalid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("no_stale", {31'd0, s_obi_rvalid}, 32'd0);
        @(posedge clk); #1;
        issue(1'b0, 32'h40, 4'h0, 32'h0, 1'b1);
        check("rst_write_dropped", s_obi_rdata, 32'h5A5A1234);
        drain();

        // Out-of-range address: error or alias depending on build
        issue(1'b1, 32'h0, 4'hF, 32'h12345678, 1'b0);
        issue(1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b1);
`ifdef OBI_SRAM_SUB_ERR_EN
        check("oor_err", {31'd0, s_obi_err}, 32'd1);
`else
        check("oor_err", {31'd0, s_obi_err}, 32'd0);
`endif
        check("oor_rid", {31'd0, s_obi_rid}, 32'd1);
        issue(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
`ifdef OBI_SRAM_SUB_ERR_EN
        check("word0_after_oor", s_obi_rdata, 32'h12345678);
`else
        check("word0_after_oor", s_obi_rdata, 32'hCAFEF00D);
`endif
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
